ap_mult_pipe: RTL and testbench

Parametrised, pipelined N×N signed (two's-complement) multiplier with a runtime-selectable approximate low-order region. It generalises the team's fixed 12-bit combinational approximate Wallace compressor into a single block that covers any even width with adjustable accuracy. Operands and accuracy mode enter through a valid/ready handshake, and the 2N-bit product leaves the same way after a 3-cycle pipeline. It sits in the datapath wherever an approximate MAC or multiplier is instantiated, and a per-transaction mode selects between exact and degraded products.

---
 rtl/ap_mult_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_ap_mult_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_mult_pipe.sv
// ---------------------------------------------------------------------------
// ap_mult_pipe
//
// Pipelined N x N signed (two's-complement) multiplier. A per-beat count k
// of low-order product columns can be made approximate. An approximate
// column is the OR of its partial-product bits and sends no carry upward.
// The remaining columns are summed exactly using Baugh-Wooley partial
// products. The operands and k enter through a valid/ready handshake. The
// 2N-bit product leaves the same way after three register stages.
//
// Parameters
//   N       operand width (even, 8..16)
//   AP_MAX  largest approximate column count honoured; larger requests clamp
//   AW      width of in_ap_cols
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in_valid    operand beat valid
//   in_ready    block can accept a beat (combinational from out_valid/out_ready)
//   in_a        multiplicand, signed
//   in_b        multiplier, signed
//   in_ap_cols  requested approximate low column count for this beat
//   out_valid   product valid
//   out_ready   downstream accepts the product
//   out_res     product, two's-complement, modulo 2^(2N)
// ---------------------------------------------------------------------------
module ap_mult_pipe #(
    parameter int N      = 12,
    parameter int AP_MAX = N,
    parameter int AW     = $clog2(2 * N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_a,
    input  logic [N-1:0]    in_b,
    input  logic [AW-1:0]   in_ap_cols,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*N-1:0]  out_res
);

    localparam int W = 2 * N;

    localparam logic [AW-1:0] K_MAX = AW'(AP_MAX);

    // Baugh-Wooley correction constants: one 1 at column N and one at
    // column 2N-1. They count as real bits of their columns. They therefore
    // take part in both the OR of approximate columns and the exact sum.
    localparam logic [W-1:0] CONST_ROW = (W'(1) << N) | (W'(1) << (W - 1));

    // -----------------------------------------------------------------------
    // Flow control. The whole pipeline moves as one: every stage advances
    // when the output slot is empty or is being drained this cycle. Bubbles
    // travel through the pipeline and are never collapsed. This keeps the
    // ready path to a single gate.
    // -----------------------------------------------------------------------
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // -----------------------------------------------------------------------
    // Stage 1: register operands and clamped column count
    // -----------------------------------------------------------------------
    logic            s1_valid;
    logic [N-1:0]    s1_a;
    logic [N-1:0]    s1_b;
    logic [AW-1:0]   s1_k;
    logic [AW-1:0]   k_clamped;

    assign k_clamped = (in_ap_cols > K_MAX) ? K_MAX : in_ap_cols;

    // The stage-1 valid flag follows in_valid whenever the pipe advances.
    // Data registers load only on an accepted beat. On a bubble they keep
    // stale contents, which is harmless because downstream logic only acts
    // on beats whose valid flag is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_k     <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a <= in_a;
                s1_b <= in_b;
                s1_k <= k_clamped;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 combinational: partial products, OR reduction, CSA compression
    // -----------------------------------------------------------------------
    logic [W-1:0] exact_mask_s1;
    logic [W-1:0] pp_row;
    logic [W-1:0] pp_exact;
    logic [W-1:0] col_or;
    logic [W-1:0] csa_sum;
    logic [W-1:0] csa_carry;
    logic [W-1:0] csa_sum_nx;
    logic [W-1:0] csa_carry_nx;
    logic         pp_bit;

    // Each multiplier bit b[i] yields one row of N partial-product bits at
    // columns i..i+N-1. The Baugh-Wooley inversion applies where exactly one
    // index is the sign position. Every bit of the row is ORed into the
    // per-column OR vector. The row's exact-column part is folded into a
    // running carry-save pair through a 3:2 compressor, one row per step.
    // Carries shifted out of the top column are dropped, which gives the
    // modulo 2^(2N) result. No bit below k enters the compressor. The
    // carry-save pair is therefore zero below k, and no carry crosses from
    // the approximate region into column k.
    always_comb begin
        exact_mask_s1 = '0;
        pp_row        = '0;
        pp_exact      = '0;
        pp_bit        = 1'b0;
        col_or        = CONST_ROW;
        csa_sum       = '0;
        csa_carry     = '0;
        csa_sum_nx    = '0;
        csa_carry_nx  = '0;

        for (int c = 0; c < W; c++) begin
            exact_mask_s1[c] = (c >= int'(s1_k));
        end

        csa_sum = CONST_ROW & exact_mask_s1;

        for (int i = 0; i < N; i++) begin
            pp_row = '0;
            for (int j = 0; j < N; j++) begin
                pp_bit = s1_a[j] & s1_b[i];
                if ((i == N - 1) != (j == N - 1)) begin
                    pp_bit = ~pp_bit;
                end
                pp_row[i + j] = pp_bit;
            end

            col_or   = col_or | pp_row;
            pp_exact = pp_row & exact_mask_s1;

            csa_sum_nx   = csa_sum ^ csa_carry ^ pp_exact;
            csa_carry_nx = ((csa_sum & csa_carry) |
                            (csa_sum & pp_exact)  |
                            (csa_carry & pp_exact)) << 1;
            csa_sum      = csa_sum_nx;
            csa_carry    = csa_carry_nx;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 registers: carry-save pair, approximate OR bits, k
    // -----------------------------------------------------------------------
    logic            s2_valid;
    logic [W-1:0]    s2_sum;
    logic [W-1:0]    s2_carry;
    logic [W-1:0]    s2_or;
    logic [AW-1:0]   s2_k;

    // Only the OR bits of the approximate columns are kept. The columns at
    // or above k come entirely from the carry-save pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_carry <= '0;
            s2_or    <= '0;
            s2_k     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum   <= csa_sum;
                s2_carry <= csa_carry;
                s2_or    <= col_or & ~exact_mask_s1;
                s2_k     <= s1_k;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 3 combinational: final carry-propagate add and merge
    // -----------------------------------------------------------------------
    logic [W-1:0] exact_mask_s2;
    logic [W-1:0] cpa_sum;
    logic [W-1:0] merged;

    // The CPA result is already zero below k. Masking it again with the
    // stage-2 copy of k makes the OR merge independent of that property.
    always_comb begin
        exact_mask_s2 = '0;
        for (int c = 0; c < W; c++) begin
            exact_mask_s2[c] = (c >= int'(s2_k));
        end
        cpa_sum = s2_sum + s2_carry;
        merged  = (cpa_sum & exact_mask_s2) | s2_or;
    end

    // -----------------------------------------------------------------------
    // Stage 3 registers: output slot
    // -----------------------------------------------------------------------
    // The output slot loads only when the pipe advances. While the consumer
    // stalls, the product and out_valid hold steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_res   <= '0;
        end else if (adv) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_res <= merged;
            end
        end
    end

endmodule

// File: tb/tb_ap_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_ap_mult_pipe
//
// Self-checking bench for ap_mult_pipe. Two instances share every input:
// one clamps at AP_MAX=6 and one allows up to 2N-1 approximate columns.
// Expected products come from a column-counting reference model or from
// known constants. They sit in per-instance queues and are compared in
// order whenever an instance shows out_valid.
// ---------------------------------------------------------------------------
module tb_ap_mult_pipe;

    localparam int N  = 12;
    localparam int W  = 2 * N;
    localparam int AW = $clog2(2 * N);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [N-1:0]    in_a;
    logic [N-1:0]    in_b;
    logic [AW-1:0]   in_ap_cols;
    logic            out_ready;

    logic            in_ready_n;
    logic            out_valid_n;
    logic [W-1:0]    out_res_n;
    logic            in_ready_w;
    logic            out_valid_w;
    logic [W-1:0]    out_res_w;

    int              testsRun     = 0;
    int              failCount    = 0;
    int              cycleCount   = 0;
    bit              strictLatency = 1'b0;

    logic [W-1:0]    expN[$];
    logic [W-1:0]    expW[$];
    int              accN[$];
    int              accW[$];

    always #5 clk = ~clk;

    ap_mult_pipe #(.N(N), .AP_MAX(6)) dut_n (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_n),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ap_cols (in_ap_cols),
        .out_valid  (out_valid_n),
        .out_ready  (out_ready),
        .out_res    (out_res_n)
    );

    ap_mult_pipe #(.N(N), .AP_MAX(2 * N - 1)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready_w),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ap_cols (in_ap_cols),
        .out_valid  (out_valid_w),
        .out_ready  (out_ready),
        .out_res    (out_res_w)
    );

    // Single point of comparison: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input longint got, input longint exp);
        testsRun++;
        if (got != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycleCount);
        end
    endtask

    // Reference model: first the true signed product. Then, for each
    // approximate column, count its Baugh-Wooley bits (constants included).
    // The exact columns carry the product minus the weighted low bit counts.
    // The approximate columns carry a 1 wherever the count is non-zero.
    function automatic logic [W-1:0] refModel(input logic [N-1:0] a, input logic [N-1:0] b,
                                              input int cols, input int apMax);
        int          k;
        int          cnt;
        logic        pp;
        longint      prod;
        longint      lowSum;
        logic [W-1:0] orBits;
        k      = (cols < apMax) ? cols : apMax;
        prod   = longint'($signed(a)) * longint'($signed(b));
        lowSum = 0;
        orBits = '0;
        for (int c = 0; c < k; c++) begin
            cnt = 0;
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    if (i + j == c) begin
                        pp = a[j] & b[i];
                        if ((i == N - 1) != (j == N - 1)) pp = ~pp;
                        cnt += int'(pp);
                    end
                end
            end
            if (c == N || c == W - 1) cnt++;
            lowSum += longint'(cnt) << c;
            if (cnt != 0) orBits[c] = 1'b1;
        end
        return W'(prod - lowSum) | orBits;
    endfunction

    // One clock cycle. Inputs are driven at the falling edge and sampled 1ns
    // later. Any visible product is compared against its queue head; it is
    // popped if consumed. An accepted beat pushes its expectations.
    task automatic applyStimulus(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic [AW-1:0] cols, input logic ordy,
                                 input bit useConst, input logic [W-1:0] cN, input logic [W-1:0] cW);
        @(negedge clk);
        in_valid   = v;
        in_a       = a;
        in_b       = b;
        in_ap_cols = cols;
        out_ready  = ordy;
        #1;
        if (out_valid_n) begin
            if (expN.size() == 0) begin
                checkOutput("spurious_out_n", 1, 0);
            end else begin
                checkOutput("out_res_n", out_res_n, expN[0]);
                if (ordy) begin
                    if (strictLatency) checkOutput("latency_n", cycleCount - accN[0], 3);
                    void'(expN.pop_front());
                    void'(accN.pop_front());
                end
            end
        end
        if (out_valid_w) begin
            if (expW.size() == 0) begin
                checkOutput("spurious_out_w", 1, 0);
            end else begin
                checkOutput("out_res_w", out_res_w, expW[0]);
                if (ordy) begin
                    if (strictLatency) checkOutput("latency_w", cycleCount - accW[0], 3);
                    void'(expW.pop_front());
                    void'(accW.pop_front());
                end
            end
        end
        if (v && in_ready_n) begin
            expN.push_back(useConst ? cN : refModel(a, b, int'(cols), 6));
            accN.push_back(cycleCount);
        end
        if (v && in_ready_w) begin
            expW.push_back(useConst ? cW : refModel(a, b, int'(cols), W - 1));
            accW.push_back(cycleCount);
        end
        cycleCount++;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic randomBeat(input logic v, input logic ordy);
        applyStimulus(v, N'($urandom), N'($urandom), AW'($urandom_range(0, 31)), ordy, 1'b0, '0, '0);
    endtask

    // Bounded drain: every queued expectation must emerge within the budget.
    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (expN.size() == 0 && expW.size() == 0) break;
            idleCycle();
        end
        checkOutput("drain_left_n", expN.size(), 0);
        checkOutput("drain_left_w", expW.size(), 0);
    endtask

    logic [W-1:0] heldN;
    logic [W-1:0] heldW;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        in_ap_cols = '0;
        out_ready  = 1'b1;
        #1;
        checkOutput("reset_out_valid", out_valid_n, 0);
        checkOutput("reset_out_res", out_res_n, 0);
        checkOutput("reset_in_ready", in_ready_n, 1);
        checkOutput("reset_out_res_w", out_res_w, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed products with known answers, back to back
        strictLatency = 1'b1;
        applyStimulus(1'b1, 12'h800, 12'h800, 5'd0, 1'b1, 1'b1, 24'h400000, 24'h400000);
        applyStimulus(1'b1, 12'h005, 12'hFFD, 5'd0, 1'b1, 1'b1, 24'hFFFFF1, 24'hFFFFF1);
        applyStimulus(1'b1, 12'h00F, 12'h00F, 5'd4, 1'b1, 1'b1, 24'h0000BF, 24'h0000BF);
        // Request beyond AP_MAX: narrow instance must behave as k=6
        applyStimulus(1'b1, 12'h00F, 12'h00F, 5'd20, 1'b1, 1'b1,
                      refModel(12'h00F, 12'h00F, 6, 6), refModel(12'h00F, 12'h00F, 20, W - 1));
        drain();

        // Back-to-back random streaming at full throughput
        for (int i = 0; i < 1000; i++) randomBeat(1'b1, 1'b1);
        drain();
        strictLatency = 1'b0;

        // Backpressure: fill the pipe, then stall the consumer for 5 cycles
        for (int i = 0; i < 3; i++) randomBeat(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            randomBeat(1'b1, 1'b0);
            checkOutput("stall_in_ready", in_ready_n, 0);
            checkOutput("stall_out_valid", out_valid_n, 1);
            if (i == 0) begin
                heldN = out_res_n;
                heldW = out_res_w;
            end else begin
                checkOutput("stall_hold_n", out_res_n, heldN);
                checkOutput("stall_hold_w", out_res_w, heldW);
            end
        end
        for (int i = 0; i < 4; i++) randomBeat(1'b1, 1'b1);
        drain();

        // Random valid and ready patterns
        for (int i = 0; i < 400; i++) randomBeat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        drain();

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) randomBeat(1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        checkOutput("midreset_out_valid", out_valid_n, 0);
        checkOutput("midreset_out_res", out_res_n, 0);
        checkOutput("midreset_out_res_w", out_res_w, 0);
        expN.delete();
        expW.delete();
        accN.delete();
        accW.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postreset_in_ready", in_ready_n, 1);
        for (int i = 0; i < 5; i++) idleCycle();
        strictLatency = 1'b1;
        applyStimulus(1'b1, 12'hFFF, 12'hFFF, 5'd0, 1'b1, 1'b1, 24'h000001, 24'h000001);
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
